dmem_lsu: RTL and testbench

//  Load/store initiator for the dmem data memory. Accepts one CPU load/store request at a time over
//  a valid/ready handshake and generates dmem write (wr_addr/wr_data/wr_en) and read (rd_addr/rd_data) traffic.

---
 rtl/dmem_lsu_if.sv | 40 ++++
 rtl/dmem_lsu.sv | 183 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Bundles the CPU request/response handshake and the dmem write/read ports of the load/store unit.
// slave is the LSU view, master is the execute-stage/dmem side that drives the LSU inputs.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_addr,
        input  mem_rd_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_addr,
        output mem_rd_data
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store initiator for dmem: one request at a time, byte-lane steering, sign extension, error checks.
// Latency accept->resp_valid: error 1, store 2, load 3 cycles; req_ready low until the response is taken.
module dmem_lsu #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic    clk,
    input  logic    rst_n,
    dmem_lsu_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DATA  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [32:0] MEM_LIM = 33'(MEM_BYTES);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [3:0]  wr_en_q, wr_en_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;

    logic [1:0]  req_off;
    logic        req_err;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_shift;
    logic [31:0] ld_val;

    assign req_off = bus.req_addr[1:0];

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'b11)                          req_err = 1'b1;
        if (bus.req_size == 2'b01 && req_off[0])            req_err = 1'b1;
        if (bus.req_size == 2'b10 && req_off != 2'b00)      req_err = 1'b1;
        if ({1'b0, bus.req_addr} >= MEM_LIM)                req_err = 1'b1;
    end

    // Store data is replicated across lanes so the mask alone selects the bytes written.
    always_comb begin
        st_mask = 4'b1111;
        st_data = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                st_mask = 4'b0001 << req_off;
                st_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << req_off;
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_shift = bus.mem_rd_data >> {off_q, 3'b000};

    always_comb begin
        ld_val = ld_shift;
        case (size_q)
            2'b00: ld_val = uns_q ? {24'h0, ld_shift[7:0]}  : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01: ld_val = uns_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 4'b0000;
        rd_addr_d    = rd_addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    size_d      = bus.req_size;
                    uns_d       = bus.req_unsigned;
                    off_d       = req_off;
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (bus.req_we) begin
                        state_d   = S_WRITE;
                        wr_en_d   = st_mask;
                        wr_addr_d = {bus.req_addr[31:2], 2'b00};
                        wr_data_d = st_data;
                    end else begin
                        state_d   = S_READ;
                        rd_addr_d = {bus.req_addr[31:2], 2'b00};
                    end
                end
            end
            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
            S_READ: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = ld_val;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            wr_addr_q    <= 32'h0;
            wr_data_q    <= 32'h0;
            wr_en_q      <= 4'b0000;
            rd_addr_q    <= 32'h0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            rd_addr_q    <= rd_addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural dmem and an expected-response queue.
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu #(.MEM_BYTES(65536)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:16383];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_wr_en[b]) mem[bus.mem_wr_addr[15:2]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
        bus.mem_rd_data <= mem[bus.mem_rd_addr[15:2]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wdata, input int hold);
        exp_t        e;
        exp_t        got_e;
        int          lat;
        bit          got;
        logic [3:0]  seen_en;
        logic [31:0] seen_wd;
        logic [31:0] seen_wa;
        logic [31:0] wa_exp;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        wa_exp  = {addr[31:2], 2'b00};
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
        sb.push_back(e);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        got = 0; lat = 0; seen_en = 4'b0; seen_wd = 32'h0; seen_wa = 32'h0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en != 4'b0) begin
                seen_en = seen_en | bus.mem_wr_en;
                seen_wd = bus.mem_wr_data;
                seen_wa = bus.mem_wr_addr;
            end
            if (bus.resp_valid) begin
                got = 1;
                lat = i;
            end
        end
        chk({tag, "_resp_seen"}, 32'(got), 32'd1);
        got_e = sb.pop_front();
        if (got) begin
            chk({tag, "_lat"},   32'(lat),           32'(got_e.lat));
            chk({tag, "_rdata"}, bus.resp_rdata,     got_e.rdata);
            chk({tag, "_err"},   32'(bus.resp_err),  32'(got_e.err));
        end
        chk({tag, "_wr_en"}, 32'(seen_en), 32'(exp_mask));
        if (exp_mask != 4'b0) begin
            chk({tag, "_wr_data"}, seen_wd, exp_wdata);
            chk({tag, "_wr_addr"}, seen_wa, wa_exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"},   32'(bus.resp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, bus.resp_rdata,      exp_rdata);
            chk({tag, "_hold_rdy"},   32'(bus.req_ready),  32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_drop"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(bus.req_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 16384; k++) mem[k] = 32'h0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst_wr_en",      32'(bus.mem_wr_en),  32'd0);
        chk("rst_wr_addr",    bus.mem_wr_addr,     32'h0);
        chk("rst_wr_data",    bus.mem_wr_data,     32'h0);
        chk("rst_rd_addr",    bus.mem_rd_addr,     32'h0);
        rst_n = 1'b1;

        // word store then load back
        do_req("t1_sw", 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 4'b1111, 32'hDEADBEEF, 0);
        do_req("t1_lw", 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 4'b0000, 32'h0, 0);

        // byte lane steering
        do_req("t2_sb0", 1, 2'b00, 0, 32'h200, 32'h00000011, 32'h0, 0, 2, 4'b0001, 32'h11111111, 0);
        do_req("t2_sb1", 1, 2'b00, 0, 32'h201, 32'hFFFFFF22, 32'h0, 0, 2, 4'b0010, 32'h22222222, 0);
        do_req("t2_sb2", 1, 2'b00, 0, 32'h202, 32'h00000033, 32'h0, 0, 2, 4'b0100, 32'h33333333, 0);
        do_req("t2_sb3", 1, 2'b00, 0, 32'h203, 32'h00000044, 32'h0, 0, 2, 4'b1000, 32'h44444444, 0);
        do_req("t2_lw",  0, 2'b10, 0, 32'h200, 32'h0, 32'h44332211, 0, 3, 4'b0000, 32'h0, 0);

        // sign/zero extension, plus an upper-half store
        do_req("t3_sw",  1, 2'b10, 0, 32'h300, 32'h80FF7F80, 32'h0, 0, 2, 4'b1111, 32'h80FF7F80, 0);
        do_req("t3_lb",  0, 2'b00, 0, 32'h300, 32'h0, 32'hFFFFFF80, 0, 3, 4'b0000, 32'h0, 0);
        do_req("t3_lbu", 0, 2'b00, 1, 32'h300, 32'h0, 32'h00000080, 0, 3, 4'b0000, 32'h0, 0);
        do_req("t3_lbu1",0, 2'b00, 0, 32'h301, 32'h0, 32'h0000007F, 0, 3, 4'b0000, 32'h0, 0);
        do_req("t3_lh",  0, 2'b01, 0, 32'h302, 32'h0, 32'hFFFF80FF, 0, 3, 4'b0000, 32'h0, 0);

        // errors: no write, rd_addr unchanged from the last load (0x300)
        do_req("t4_sh_mis", 1, 2'b01, 0, 32'h101,   32'hCAFEF00D, 32'h0, 1, 1, 4'b0000, 32'h0, 0);
        do_req("t4_lw_mis", 0, 2'b10, 0, 32'h102,   32'h0,        32'h0, 1, 1, 4'b0000, 32'h0, 0);
        do_req("t4_size11", 1, 2'b11, 0, 32'h100,   32'h12345678, 32'h0, 1, 1, 4'b0000, 32'h0, 0);
        do_req("t4_oor",    0, 2'b10, 0, 32'h10000, 32'h0,        32'h0, 1, 1, 4'b0000, 32'h0, 0);
        chk("t4_mem_100", mem[32'h100 >> 2], 32'hDEADBEEF);
        chk("t4_rd_addr", bus.mem_rd_addr, 32'h300);

        // last valid byte address
        do_req("b_sb_top", 1, 2'b00, 0, 32'hFFFF, 32'h0000005A, 32'h0, 0, 2, 4'b1000, 32'h5A5A5A5A, 0);
        do_req("b_lbu_top",0, 2'b00, 1, 32'hFFFF, 32'h0, 32'h0000005A, 0, 3, 4'b0000, 32'h0, 0);
        do_req("b_sh_hi",  1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'h0, 0, 2, 4'b1100, 32'hABCDABCD, 0);
        do_req("b_lw_hi",  0, 2'b10, 0, 32'h300, 32'h0, 32'hABCD7F80, 0, 3, 4'b0000, 32'h0, 0);

        // backpressure on the response
        do_req("t5_hold", 0, 2'b10, 0, 32'h200, 32'h0, 32'h44332211, 0, 3, 4'b0000, 32'h0, 5);

        // reset during WRITE
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h100; bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_wr_en_write", 32'(bus.mem_wr_en), 32'hF);
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en_async", 32'(bus.mem_wr_en), 32'h0);
        repeat (2) @(negedge clk);
        chk("t6_mem_kept",  mem[32'h100 >> 2], 32'hDEADBEEF);
        chk("t6_no_resp",   32'(bus.resp_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rdy_after", 32'(bus.req_ready),  32'd1);
        chk("t6_no_resp2",  32'(bus.resp_valid), 32'd0);

        do_req("t6_lw", 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 4'b0000, 32'h0, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
